// File: rtl/alarm_pkg.sv
// Shared alarm definitions: time word layout, meridian codes and ring-controller state encoding.
package alarm_pkg;

  localparam int unsigned TIME_W       = 17;
  localparam int unsigned MERIDIAN_BIT = 16;
  localparam int unsigned HOUR_LSB     = 12;
  localparam int unsigned HOUR_W       = 4;
  localparam int unsigned MIN_LSB      = 6;
  localparam int unsigned MIN_W        = 6;
  localparam int unsigned SEC_LSB      = 0;
  localparam int unsigned SEC_W        = 6;

  localparam logic MERIDIAN_AM = 1'b0;
  localparam logic MERIDIAN_PM = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  typedef struct packed {
    logic              meridian;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } alarm_time_t;

  function automatic alarm_time_t make_time(input logic              pm,
                                            input logic [HOUR_W-1:0] hour,
                                            input logic [MIN_W-1:0]  min,
                                            input logic [SEC_W-1:0]  sec);
    alarm_time_t t;
    t.meridian = pm;
    t.hour     = hour;
    t.min      = min;
    t.sec      = sec;
    return t;
  endfunction

endpackage

// File: rtl/alarm_sec_counter.sv
// Tick-driven seconds down-counter with load and a terminal (zero) flag; shared by the
// ring timeout and the snooze interval.
module alarm_sec_counter #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_c = (cnt_q == '0);

endmodule

// File: rtl/alarm_ring_cont.sv
// Alarm ring controller: detects the alarm-time match, rings with a 1 s buzzer pattern,
// times out, and (when ALARM_SNOOZE_EN is defined) handles snooze re-arming.
module alarm_ring_cont
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [TIME_W-1:0]                CUR_TIME,
  input  logic [TIME_W-1:0]                ALARM_TIME,
  input  logic                             ALARM_EN,
  input  logic                             SEC_TICK,
  input  logic                             STOP,
  input  logic                             SNOOZE,
  output logic                             RING,
  output logic                             BUZZ,
  output logic                             MISSED,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]  SNOOZE_CNT
);

  localparam int unsigned CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SEC - 1);

  logic [1:0]       state_q, state_d;
  logic             eq_prev_q, eq_prev_d;
  logic             buzz_q, buzz_d;
  logic             missed_q, missed_d;
  logic             eq, trig;
  logic             cnt_clr, cnt_load, cnt_en, cnt_term;
  logic [CNT_W-1:0] cnt_load_val;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned      SNC_W    = $clog2(MAX_SNOOZE + 1);
  localparam logic [CNT_W-1:0] SNZ_LOAD = CNT_W'(SNOOZE_SEC - 1);
  logic [SNC_W-1:0] snz_cnt_q, snz_cnt_d;
`else
  logic snooze_unused;
  assign snooze_unused = SNOOZE;
`endif

  // Rising edge of the match; eq_prev resets high so an equal time at reset release is not a trigger.
  assign eq        = (CUR_TIME == ALARM_TIME);
  assign trig      = eq & ~eq_prev_q & ALARM_EN;
  assign eq_prev_d = eq;

  always_comb begin
    state_d      = state_q;
    buzz_d       = buzz_q;
    missed_d     = missed_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = RING_LOAD;
    cnt_en       = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d    = snz_cnt_q;
`endif
    if (!ALARM_EN) begin
      state_d  = ST_IDLE;
      buzz_d   = 1'b0;
      missed_d = 1'b0;
      cnt_clr  = 1'b1;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d = '0;
`endif
    end else begin
      if (STOP) missed_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_d  = ST_RINGING;
            buzz_d   = 1'b1;
            cnt_load = 1'b1;
          end
        end
        ST_RINGING: begin
          if (STOP) begin
            state_d = ST_IDLE;
            buzz_d  = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_d = '0;
          end else if (SNOOZE) begin
            buzz_d = 1'b0;
            // Snooze beyond the allowance behaves as a stop.
            if (snz_cnt_q < SNC_W'(MAX_SNOOZE)) begin
              state_d      = ST_SNOOZED;
              snz_cnt_d    = snz_cnt_q + SNC_W'(1);
              cnt_load     = 1'b1;
              cnt_load_val = SNZ_LOAD;
            end else begin
              state_d   = ST_IDLE;
              snz_cnt_d = '0;
            end
`endif
          end else if (SEC_TICK) begin
            if (cnt_term) begin
              state_d  = ST_IDLE;
              buzz_d   = 1'b0;
              missed_d = 1'b1;
`ifdef ALARM_SNOOZE_EN
              snz_cnt_d = '0;
`endif
            end else begin
              buzz_d = ~buzz_q;
              cnt_en = 1'b1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZED: begin
          if (STOP) begin
            state_d   = ST_IDLE;
            snz_cnt_d = '0;
          end else if (SEC_TICK) begin
            if (cnt_term) begin
              state_d  = ST_RINGING;
              buzz_d   = 1'b1;
              cnt_load = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          buzz_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      eq_prev_q <= 1'b1;
      buzz_q    <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      eq_prev_q <= eq_prev_d;
      buzz_q    <= buzz_d;
      missed_q  <= missed_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      snz_cnt_q <= '0;
    end else begin
      snz_cnt_q <= snz_cnt_d;
    end
  end

  assign SNOOZE_CNT = snz_cnt_q;
`else
  assign SNOOZE_CNT = '0;
`endif

  alarm_sec_counter #(
    .W (CNT_W)
  ) u_sec_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .term_c   (cnt_term)
  );

  assign RING   = (state_q == ST_RINGING);
  assign BUZZ   = buzz_q;
  assign MISSED = missed_q;

endmodule

// File: tb/tb_alarm_ring_cont.sv
// Bench for alarm_ring_cont: vector table, hand-written corner sequences and a randomized
// run against an elapsed-seconds reference model. Follows ALARM_SNOOZE_EN like the design.
module tb_alarm_ring_cont;
  import alarm_pkg::*;

  localparam int unsigned RING_SEC   = 6;
  localparam int unsigned SNOOZE_SEC = 5;
  localparam int unsigned MAX_SNOOZE = 2;
  localparam int unsigned SNC_W      = $clog2(MAX_SNOOZE + 1);
  localparam int unsigned OUT_W      = 3 + SNC_W;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en_r, tick_r, stop_r, snz_r;
  logic [TIME_W-1:0] cur_r, alm_r;
  logic              ring, buzz, missed;
  logic [SNC_W-1:0]  snc;

  always #5 clk = ~clk;

  alarm_ring_cont #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .CUR_TIME   (cur_r),
    .ALARM_TIME (alm_r),
    .ALARM_EN   (en_r),
    .SEC_TICK   (tick_r),
    .STOP       (stop_r),
    .SNOOZE     (snz_r),
    .RING       (ring),
    .BUZZ       (buzz),
    .MISSED     (missed),
    .SNOOZE_CNT (snc)
  );

  typedef struct {
    logic              en;
    logic [TIME_W-1:0] cur;
    logic [TIME_W-1:0] alm;
    logic              tick;
    logic              stop;
    logic              snz;
    logic [OUT_W-1:0]  exp;
  } vec_t;

  vec_t              tbl[$];
  int                n_cmp, n_bad;
  logic [TIME_W-1:0] T0, T1, T0PM, OTH;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozed; secs = ticks seen since entering the mode.
  int m_mode, m_secs, m_snc;
  bit m_prev_eq, m_missed;

  function automatic logic [OUT_W-1:0] pk(input bit r, input bit b, input bit m, input int s);
    return {r, b, m, SNC_W'(s)};
  endfunction

  function automatic logic [OUT_W-1:0] m_out();
    return pk(m_mode == 1, (m_mode == 1) && ((m_secs % 2) == 0), m_missed, m_snc);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_snc = 0; m_prev_eq = 1'b1; m_missed = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [TIME_W-1:0] cur, input logic [TIME_W-1:0] alm,
                            input bit tick, input bit stop, input bit snz);
    bit eq, rise, snz_eff;
    eq        = (cur == alm);
    rise      = eq && !m_prev_eq;
    m_prev_eq = eq;
    snz_eff   = SNZ && snz && !stop;
    if (!en) begin
      m_mode = 0; m_secs = 0; m_snc = 0; m_missed = 1'b0;
      return;
    end
    if (stop) m_missed = 1'b0;
    case (m_mode)
      0: if (rise) begin m_mode = 1; m_secs = 0; end
      1: begin
        if (stop) begin
          m_mode = 0; m_snc = 0;
        end else if (snz_eff) begin
          if (m_snc < int'(MAX_SNOOZE)) begin m_snc++; m_mode = 2; m_secs = 0; end
          else begin m_mode = 0; m_snc = 0; end
        end else if (tick) begin
          m_secs++;
          if (m_secs == int'(RING_SEC)) begin m_mode = 0; m_missed = 1'b1; m_snc = 0; end
        end
      end
      default: begin
        if (stop) begin
          m_mode = 0; m_snc = 0;
        end else if (tick) begin
          m_secs++;
          if (m_secs == int'(SNOOZE_SEC)) begin m_mode = 1; m_secs = 0; end
        end
      end
    endcase
  endtask

  task automatic check(input string nm, input logic [OUT_W-1:0] exp);
    logic [OUT_W-1:0] act;
    act = {ring, buzz, missed, snc};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: ring/buzz/missed/snooze_cnt got %b required %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit tick, input bit stop, input bit snz);
    tick_r = tick; stop_r = stop; snz_r = snz;
    model_step(en_r, cur_r, alm_r, tick, stop, snz);
    @(posedge clk);
    #1;
    tick_r = 1'b0; stop_r = 1'b0; snz_r = 1'b0;
  endtask

  task automatic trig_ring(input string nm);
    cur_r = OTH; alm_r = T0;
    cyc(0, 0, 0);
    cur_r = T0;
    cyc(0, 0, 0);
    check(nm, pk(1, 1, 0, 0));
  endtask

  task automatic add(input logic en, input logic [TIME_W-1:0] cur, input logic [TIME_W-1:0] alm,
                     input logic tick, input logic stop, input logic snz, input logic [OUT_W-1:0] exp);
    vec_t v;
    v.en = en; v.cur = cur; v.alm = alm; v.tick = tick; v.stop = stop; v.snz = snz; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    T0   = make_time(MERIDIAN_AM, 4'd7, 6'd30, 6'd0);
    T1   = make_time(MERIDIAN_AM, 4'd7, 6'd30, 6'd1);
    T0PM = make_time(MERIDIAN_PM, 4'd7, 6'd30, 6'd0);
    OTH  = make_time(MERIDIAN_AM, 4'd7, 6'd29, 6'd59);

    rst = 1'b1; en_r = 1'b1; cur_r = T0; alm_r = T0;
    tick_r = 1'b0; stop_r = 1'b0; snz_r = 1'b0;
    #1 check("reset_outputs", pk(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      check("no_ring_equal_at_reset", pk(0, 0, 0, 0));
    end

    add(1, OTH,  T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(1, T0PM, T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(1, T0,   T0,  0, 0, 0, pk(1, 1, 0, 0));
    add(1, T0,   T0,  0, 0, 0, pk(1, 1, 0, 0));
    add(1, T0,   T0,  1, 0, 0, pk(1, 0, 0, 0));
    add(1, T0,   T0,  1, 0, 0, pk(1, 1, 0, 0));
    add(1, T0,   T0,  0, 1, 0, pk(0, 0, 0, 0));
    add(1, T0,   T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(1, T0,   T0,  1, 0, 0, pk(0, 0, 0, 0));
    add(1, OTH,  T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(1, T0,   T0,  0, 0, 0, pk(1, 1, 0, 0));
    add(1, T0,   T0,  0, 1, 1, pk(0, 0, 0, 0));
    add(1, OTH,  T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(1, OTH,  OTH, 0, 0, 0, pk(1, 1, 0, 0));
    add(1, OTH,  OTH, 0, 0, 1, pk(!SNZ, !SNZ, 0, SNZ ? 1 : 0));
    add(0, OTH,  OTH, 0, 0, 0, pk(0, 0, 0, 0));
    add(1, OTH,  OTH, 0, 0, 0, pk(0, 0, 0, 0));
    add(1, OTH,  T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(0, T0,   T0,  0, 0, 0, pk(0, 0, 0, 0));
    add(1, T0,   T0,  0, 0, 0, pk(0, 0, 0, 0));
    foreach (tbl[i]) begin
      en_r = tbl[i].en; cur_r = tbl[i].cur; alm_r = tbl[i].alm;
      cyc(tbl[i].tick, tbl[i].stop, tbl[i].snz);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Timeout on the RING_SEC-th tick, then STOP clears MISSED.
    trig_ring("timeout_trig");
    for (int k = 1; k <= int'(RING_SEC); k++) begin
      cyc(1, 0, 0);
      check($sformatf("timeout_tick%0d", k),
            (k < int'(RING_SEC)) ? pk(1, (k % 2) == 0, 0, 0) : pk(0, 0, 1, 0));
    end
    cyc(0, 1, 0);
    check("stop_clears_missed", pk(0, 0, 0, 0));

    trig_ring("timeout2_trig");
    repeat (RING_SEC) cyc(1, 0, 0);
    check("timeout2", pk(0, 0, 1, 0));
    cyc(0, 0, 1);
    check("idle_snooze_keeps_missed", pk(0, 0, 1, 0));
    en_r = 1'b0;
    cyc(0, 0, 0);
    check("en_low_clears_missed", pk(0, 0, 0, 0));
    en_r = 1'b1;

    trig_ring("stop_vs_timeout_trig");
    repeat (RING_SEC - 1) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("stop_beats_timeout", pk(0, 0, 0, 0));

`ifdef ALARM_SNOOZE_EN
    trig_ring("snooze_trig");
    cyc(1, 0, 0);
    check("snooze_one_sec_in", pk(1, 0, 0, 0));
    cyc(0, 0, 1);
    check("snooze1", pk(0, 0, 0, 1));
    for (int k = 1; k <= int'(SNOOZE_SEC); k++) begin
      cyc(1, 0, 0);
      check($sformatf("snooze_tick%0d", k), (k < int'(SNOOZE_SEC)) ? pk(0, 0, 0, 1) : pk(1, 1, 0, 1));
    end
    cyc(0, 0, 1);
    check("snooze2", pk(0, 0, 0, 2));
    repeat (SNOOZE_SEC) cyc(1, 0, 0);
    check("rering2", pk(1, 1, 0, 2));
    cyc(0, 0, 1);
    check("snooze_at_limit", pk(0, 0, 0, 0));

    trig_ring("snooze_stop_trig");
    cyc(0, 0, 1);
    repeat (SNOOZE_SEC - 1) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("stop_beats_rering", pk(0, 0, 0, 0));
`else
    trig_ring("snooze_off_trig");
    cyc(0, 0, 1);
    check("snooze_ignored", pk(1, 1, 0, 0));
    cyc(1, 0, 1);
    check("snooze_ignored_tick", pk(1, 0, 0, 0));
    cyc(0, 1, 0);
    check("snooze_off_stop", pk(0, 0, 0, 0));
`endif

    // ALARM_EN dropped after a snooze pulse: idle at once and no later re-ring.
    trig_ring("en_drop_trig");
    cyc(0, 0, 1);
    check("en_drop_snooze", pk(!SNZ, !SNZ, 0, SNZ ? 1 : 0));
    en_r = 1'b0;
    cyc(0, 0, 0);
    check("en_drop_idle", pk(0, 0, 0, 0));
    en_r = 1'b1;
    for (int k = 0; k < 2 * int'(SNOOZE_SEC); k++) begin
      cyc(1, 0, 0);
      check("en_drop_no_rering", pk(0, 0, 0, 0));
    end

    // Reset mid-ring drops outputs without waiting for a clock edge.
    trig_ring("reset_trig");
    rst = 1'b1;
    #1 check("async_reset", pk(0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cyc(0, 0, 0);
    check("after_reset_no_ring", pk(0, 0, 0, 0));

    for (int i = 0; i < 4000; i++) begin
      en_r = ($urandom_range(79) != 0);
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0:       cur_r = T0;
          1:       cur_r = T1;
          default: cur_r = T0PM;
        endcase
      end
      if ($urandom_range(99) == 0) alm_r = ($urandom_range(1) == 0) ? T0 : T1;
      cyc($urandom_range(1) == 0, $urandom_range(24) == 0, $urandom_range(9) == 0);
      check($sformatf("rand%0d", i), m_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_ring_cont.md
# alarm_ring_cont

Downstream consumer of the alarm-time controller's 17-bit alarm time.
- Compares the alarm time against the running clock time.
- Raises and times out the ring, and manages snooze re-arming.
- Drives the buzzer pattern and the ring indicator for the display/LED stage.
- Counts in seconds using a 1 Hz strobe from the clock divider.

## Interface
- RING_SEC, 60: seconds a ring lasts before auto-stop (≥1)
- SNOOZE_SEC, 300: snooze interval in seconds (≥1)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (≥1)
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- CUR_TIME  in  17  current time {MERIDIAN[16], HOUR[15:12], MIN[11:6], SEC[5:0]}
- ALARM_TIME  in  17  alarm time, same format (from alarm-time controller OUT_TIME)
- ALARM_EN  in  1  alarm armed (level)
- SEC_TICK  in  1  one-cycle 1 Hz strobe
- STOP  in  1  one-cycle user stop pulse
- SNOOZE  in  1  one-cycle user snooze pulse
- RING  out  1  high while in RINGING
- BUZZ  out  1  buzzer drive, 1 s on / 1 s off while ringing
- MISSED  out  1  sticky: ring timed out without user action
- SNOOZE_CNT  out  $clog2(MAX_SNOOZE+1)  snoozes used in the current event

## Operation
- Equality `eq = (CUR_TIME == ALARM_TIME)`: full 17-bit compare, meridian included.
- Register `eq_d`. Trigger = `eq & ~eq_d & ALARM_EN`. A single match second triggers exactly once.
- States:
  - IDLE → RINGING on trigger.
  - RINGING → IDLE on STOP, or on timeout (sets MISSED).
  - RINGING → SNOOZED on SNOOZE if SNOOZE_CNT < MAX_SNOOZE. SNOOZE_CNT increments on this transition.
  - RINGING → IDLE on SNOOZE if SNOOZE_CNT == MAX_SNOOZE; treated as STOP.
  - SNOOZED → RINGING when SNOOZE_SEC ticks have elapsed.
  - SNOOZED → IDLE on STOP.
- Entering RINGING clears the second counter.
- Timeout: on the SEC_TICK where the second counter == RING_SEC-1.
- SNOOZED counts SEC_TICKs; it re-rings on the tick where the count == SNOOZE_SEC-1.
- Entering IDLE by STOP (or by SNOOZE at the limit) clears SNOOZE_CNT. Entering IDLE by timeout also clears SNOOZE_CNT.
- MISSED:
  - Set on timeout.
  - Cleared by STOP in any state, or by ALARM_EN low.
- BUZZ:
  - Set to 1 on RINGING entry.
  - Toggles on each SEC_TICK while in RINGING.
  - 0 in all other states.
- Priorities:
  - ALARM_EN low beats everything: forces IDLE immediately and clears counters and SNOOZE_CNT.
  - STOP beats SNOOZE.
  - STOP/SNOOZE beat a same-cycle timeout or re-ring.
- Trigger is ignored outside IDLE.
- STOP/SNOOZE are ignored in IDLE, except that STOP clears MISSED.
- An ALARM_TIME edit that makes eq rise while armed is a legal trigger.

## Timing
- Reset values:
  - Outputs: RING=0, BUZZ=0, MISSED=0, SNOOZE_CNT=0.
  - Internal: state=IDLE, counters=0, `eq_d`=1. No ring is produced if the times are already equal when reset releases.
- All outputs are registered or decoded from registered state.
- RING/BUZZ rise 1 cycle after the first cycle where eq is high.
- RING falls 1 cycle after STOP, SNOOZE, timeout tick, or ALARM_EN low.
- A SNOOZE taken at 1 s into the ring re-rings SNOOZE_SEC ticks after the snooze pulse, not measured from ring start.
- A RESET asserted mid-ring drops RING/BUZZ asynchronously.

## Configuration
- ALARM_SNOOZE_EN
  - Defined: snooze behaviour as above.
  - Undefined: SNOOZE input ignored, SNOOZED state and snooze counter not built, SNOOZE_CNT tied 0.

## Structure
- Shared package `alarm_pkg`:
  - Ring state encoding (IDLE, RINGING, SNOOZED).
  - Time field offsets/widths (MERIDIAN bit 16, HOUR 15:12, MIN 11:6, SEC 5:0).
  - AM/PM encodings, shared with the alarm-time controller.
- One sub-module, `alarm_sec_counter`: tick-driven down-counter with load, enable, and terminal flag. One instance is shared by RINGING timeout and SNOOZED interval, loaded with RING_SEC-1 or SNOOZE_SEC-1 on state entry.

## Test plan
- ALARM_EN=1, ALARM_TIME=7:30:00 AM, CUR_TIME steps to 7:30:00 AM → RING=1, BUZZ=1 next cycle. BUZZ toggles each tick.
- Ringing, no input, RING_SEC=60 → RING drops on 60th tick, MISSED=1. STOP then → MISSED=0.
- Ringing, SNOOZE pulse, SNOOZE_SEC=300 → RING=0, SNOOZE_CNT=1. RING=1 again after 300 ticks. Fourth SNOOZE (MAX_SNOOZE=3) → IDLE, SNOOZE_CNT=0.
- STOP during ring, CUR_TIME still equal for rest of second → no retrigger. STOP and SNOOZE in same cycle → IDLE, SNOOZE_CNT=0.
- ALARM_EN dropped while SNOOZED → IDLE immediately, no re-ring after 300 ticks. RESET pulse mid-ring → all outputs 0 asynchronously.
- Build without ALARM_SNOOZE_EN, SNOOZE pulse while ringing → still RINGING, SNOOZE_CNT=0.
